// File: rtl/rvfi_bmc_pkg.sv
// Shared helpers for the RVFI BMC sequencer: wait-counter sizing, port limit and
// elaboration-time parameter bound checks.
`ifndef RVFI_BMC_PKG_SV
`define RVFI_BMC_PKG_SV

// Parameter bound checks, expanded at module scope so a bad configuration fails elaboration.
`define RVFI_BMC_CHECK_DEPTH(depth, cycle_w) \
    if (!((depth) < ((2 ** (cycle_w)) - 1))) begin : g_bad_depth \
        $error("rvfi_bmc: DEPTH must be below 2**CYCLE_W-1"); \
    end

`define RVFI_BMC_CHECK_RESET_CYCLES(reset_cycles, cycle_w) \
    if (((reset_cycles) < 1) || ((reset_cycles) >= ((2 ** (cycle_w)) - 1))) begin : g_bad_reset_cycles \
        $error("rvfi_bmc: RESET_CYCLES must be >= 1 and below 2**CYCLE_W-1"); \
    end

package rvfi_bmc_pkg;

    localparam int MAX_PORTS = 4;

    // The counter must reach MAX_WAIT+1 so an overrun stays distinguishable from the limit.
    function automatic int wait_w(input int max_wait);
        return $clog2(max_wait + 2);
    endfunction

endpackage

`endif

// File: rtl/rvfi_bmc_sequencer_if.sv
// Memory-port bundle between the core under test (master) and the BMC sequencer (slave).
interface rvfi_bmc_sequencer_if #(
    parameter int NUM_PORTS = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);

    logic [NUM_PORTS-1:0]            mem_valid;
    logic [NUM_PORTS-1:0]            mem_ready;
    logic [NUM_PORTS-1:0]            mem_instr;
    logic [NUM_PORTS*ADDR_W-1:0]     mem_addr;
    logic [NUM_PORTS*DATA_W-1:0]     mem_wdata;
    logic [NUM_PORTS*DATA_W/8-1:0]   mem_wstrb;
    logic [NUM_PORTS-1:0]            force_ready;
    logic [NUM_PORTS-1:0]            wait_err;
    logic [NUM_PORTS-1:0]            stable_err;

    modport master (
        output mem_valid, mem_ready, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  force_ready, wait_err, stable_err
    );

    modport slave (
        input  mem_valid, mem_ready, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output force_ready, wait_err, stable_err
    );

endinterface

// File: rtl/rvfi_bmc_port_mon.sv
// Per-port handshake monitor: bounded wait-state counter, force_ready and wait_err.
// Optional request-stability capture when MEM_STABLE_CHECK_EN is defined.
module rvfi_bmc_port_mon
    import rvfi_bmc_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  valid,
    input  logic                  ready,
    input  logic                  instr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  force_ready,
    output logic                  wait_err,
    output logic                  stable_err
);

    localparam int WW = wait_w(MAX_WAIT);
    localparam logic [WW-1:0] WCNT_LIMIT = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WCNT_SAT   = WW'(MAX_WAIT + 1);

    logic [WW-1:0] wcnt_reg;
    logic [WW-1:0] wcnt_next;
    logic          wait_err_reg;
    logic          stall;
    logic          at_limit;

    assign stall    = en && valid && !ready;
    assign at_limit = (wcnt_reg == WCNT_LIMIT);

    // Any cycle that is not a stall (idle, accepted, or core held in reset) restarts the count.
    always_comb begin
        wcnt_next = '0;
        if (stall) begin
            wcnt_next = (wcnt_reg == WCNT_SAT) ? wcnt_reg : wcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wcnt_reg     <= '0;
            wait_err_reg <= 1'b0;
        end else begin
            wcnt_reg <= wcnt_next;
            if (stall && at_limit) begin
                wait_err_reg <= 1'b1;
            end
        end
    end

    assign force_ready = en && valid && at_limit;
    assign wait_err    = wait_err_reg;

`ifdef MEM_STABLE_CHECK_EN
    logic                stalled_reg;
    logic                stable_err_reg;
    logic                instr_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W/8-1:0] wstrb_reg;
    logic                changed;

    // A stalled request must be presented unchanged until it is accepted.
    assign changed = !valid || (instr != instr_reg) || (addr != addr_reg) ||
                     (wdata != wdata_reg) || (wstrb != wstrb_reg);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stalled_reg    <= 1'b0;
            stable_err_reg <= 1'b0;
            instr_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
        end else begin
            stalled_reg <= stall;
            if (stall) begin
                instr_reg <= instr;
                addr_reg  <= addr;
                wdata_reg <= wdata;
                wstrb_reg <= wstrb;
            end
            if (en && stalled_reg && changed) begin
                stable_err_reg <= 1'b1;
            end
        end
    end

    assign stable_err = stable_err_reg;
`else
    logic unused_fields;
    assign unused_fields = ^{instr, addr, wdata, wstrb};
    assign stable_err    = 1'b0;
`endif

endmodule

// File: rtl/rvfi_bmc_sequencer.sv
// RVFI BMC harness sequencer: core reset, saturating cycle counter, checker enable at DEPTH,
// per-port handshake monitors and the env_ok assume condition. Optional: MEM_STABLE_CHECK_EN.
module rvfi_bmc_sequencer
    import rvfi_bmc_pkg::*;
#(
    parameter int DEPTH        = 20,
    parameter int RESET_CYCLES = 1,
    parameter int CYCLE_W      = 8,
    parameter int STICKY_EN    = 0,
    parameter int MAX_WAIT     = 4,
    parameter int NUM_PORTS    = 1,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 core_resetn,
    output logic                 check_enable,
    output logic [CYCLE_W-1:0]   cycle,
    input  logic                 trap,
    rvfi_bmc_sequencer_if.slave  mem,
    output logic                 trap_seen,
    output logic                 env_ok
);

    `RVFI_BMC_CHECK_DEPTH(DEPTH, CYCLE_W)
    `RVFI_BMC_CHECK_RESET_CYCLES(RESET_CYCLES, CYCLE_W)

    if ((NUM_PORTS < 1) || (NUM_PORTS > MAX_PORTS)) begin : g_bad_num_ports
        $error("rvfi_bmc: NUM_PORTS must be 1..MAX_PORTS");
    end

    localparam logic [CYCLE_W-1:0] CYCLE_MAX   = '1;
    localparam logic [CYCLE_W-1:0] DEPTH_C     = CYCLE_W'(DEPTH);
    localparam logic [CYCLE_W-1:0] RESET_END_C = CYCLE_W'(RESET_CYCLES);

    logic [CYCLE_W-1:0]   cycle_reg;
    logic                 check_enable_reg;
    logic                 check_enable_next;
    logic                 trap_seen_reg;
    logic [NUM_PORTS-1:0] force_ready_vec;
    logic [NUM_PORTS-1:0] wait_err_vec;
    logic [NUM_PORTS-1:0] stable_err_vec;

    assign core_resetn = (cycle_reg >= RESET_END_C);

    always_comb begin
        check_enable_next = (cycle_reg == DEPTH_C);
        if (STICKY_EN != 0) begin
            check_enable_next = (cycle_reg >= DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_reg        <= '0;
            check_enable_reg <= 1'b0;
            trap_seen_reg    <= 1'b0;
        end else begin
            if (cycle_reg != CYCLE_MAX) begin
                cycle_reg <= cycle_reg + 1'b1;
            end
            check_enable_reg <= check_enable_next;
            // Traps while the core is still held in reset are expected noise.
            if (core_resetn && trap) begin
                trap_seen_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        rvfi_bmc_port_mon #(
            .MAX_WAIT (MAX_WAIT),
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W)
        ) u_mon (
            .clk         (clk),
            .resetn      (resetn),
            .en          (core_resetn),
            .valid       (mem.mem_valid[gi]),
            .ready       (mem.mem_ready[gi]),
            .instr       (mem.mem_instr[gi]),
            .addr        (mem.mem_addr[gi*ADDR_W +: ADDR_W]),
            .wdata       (mem.mem_wdata[gi*DATA_W +: DATA_W]),
            .wstrb       (mem.mem_wstrb[gi*(DATA_W/8) +: (DATA_W/8)]),
            .force_ready (force_ready_vec[gi]),
            .wait_err    (wait_err_vec[gi]),
            .stable_err  (stable_err_vec[gi])
        );
    end

    assign mem.force_ready = force_ready_vec;
    assign mem.wait_err    = wait_err_vec;
    assign mem.stable_err  = stable_err_vec;

    assign cycle        = cycle_reg;
    assign check_enable = check_enable_reg;
    assign trap_seen    = trap_seen_reg;
    assign env_ok       = ~|wait_err_vec & ~|stable_err_vec & ~trap_seen_reg;

endmodule
